bitstream_writer: RTL and testbench

//  Encoder-side counterpart of the parser bit-pointer logic. It accepts one syntax element per

---
 rtl/bitstream_writer.sv | 195 +++++++++++++++++++
 tb/tb_bitstream_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_writer.sv
// Packs fixed/ue/se/rbsp-trailing/start-code syntax elements MSB-first into bytes; optional emulation prevention under `BITSTREAM_WRITER_EPB_EN.
// Latency: an element that completes a byte shows byte_valid one edge after it is accepted; one byte per cycle at most.
// Backpressure: wr_ready drops while 8+ bits are pending, outside S_ACC, or while the output byte is stalled by byte_ready.
module bitstream_writer #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_mode,
    input  logic [15:0]      wr_value,
    input  logic [4:0]       wr_len,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             idle
);
    localparam int FW = $clog2(ACC_W + 1);

    localparam logic [2:0] M_FIXED = 3'd0;
    localparam logic [2:0] M_UE    = 3'd1;
    localparam logic [2:0] M_SE    = 3'd2;
    localparam logic [2:0] M_RBSP  = 3'd3;
    localparam logic [2:0] M_SC    = 3'd4;

`ifdef BITSTREAM_WRITER_EPB_EN
    typedef enum logic [1:0] {S_ACC, S_SC, S_EPB} state_t;
`else
    typedef enum logic [1:0] {S_ACC, S_SC} state_t;
`endif

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [FW-1:0]    fill;
    logic [1:0]       zero_run;
    logic [1:0]       sc_cnt;

    logic [16:0]      code_num;
    logic [16:0]      ue_k;
    logic [4:0]       ue_n;
    logic [4:0]       fix_len;
    logic [31:0]      cw;
    logic [FW-1:0]    cw_len;
    logic [FW-1:0]    cnt_inc;
    logic [FW-1:0]    sh;
    logic [ACC_W-1:0] placed;
    logic [ACC_W-1:0] acc_app;
    logic [FW-1:0]    fill_app;
    logic [7:0]       cand;
    logic             out_free;
    logic             accept;
    logic             drain;
    logic             epb_hit;

    // se(v) maps to codeNum first, then both share the Exp-Golomb path.
    always_comb begin
        code_num = {1'b0, wr_value};
        if (wr_mode == M_SE) begin
            if (!wr_value[15] && (wr_value != 16'd0)) begin
                code_num = {wr_value, 1'b0} - 17'd1;
            end else begin
                code_num = 17'd0 - {wr_value, 1'b0};
            end
        end
        ue_k = code_num + 17'd1;
        ue_n = '0;
        for (int i = 1; i < 17; i++) begin
            if (ue_k[i]) begin
                ue_n = 5'(i);
            end
        end
    end

    // Exp-Golomb codeword is just k right-aligned in 2n+1 bits: the n leading zeros come for free.
    always_comb begin
        fix_len = (wr_len > 5'd16) ? 5'd16 : wr_len;
        cw      = '0;
        cw_len  = '0;
        case (wr_mode)
            M_FIXED: begin
                cw_len = FW'(fix_len);
                cw     = {16'd0, wr_value} & ((32'd1 << fix_len) - 32'd1);
            end
            M_UE, M_SE: begin
                cw_len = FW'({ue_n, 1'b0}) + FW'(1);
                cw     = {15'd0, ue_k};
            end
            M_RBSP: begin
                cw_len = FW'(4'd8 - {1'b0, fill[2:0]});
                cw     = 32'd1 << (cw_len - FW'(1));
            end
            default: begin
                cw     = '0;
                cw_len = '0;
            end
        endcase
        cnt_inc = (wr_mode == M_SC) ? FW'(32) : cw_len;
    end

    assign out_free = !byte_valid || byte_ready;
    assign wr_ready = (state == S_ACC) && (fill < FW'(8)) &&
                      ((wr_mode != M_SC) || (fill == '0)) &&
                      !(byte_valid && !byte_ready);
    assign accept   = wr_valid && wr_ready;
    assign drain    = (state == S_ACC) && (fill >= FW'(8)) && out_free;
    assign cand     = acc[ACC_W-1 -: 8];

    assign sh       = FW'(ACC_W) - fill - cw_len;
    assign placed   = {{(ACC_W-32){1'b0}}, cw} << sh;
    assign acc_app  = accept ? (acc | placed) : acc;
    assign fill_app = accept ? (fill + cw_len) : fill;

`ifdef BITSTREAM_WRITER_EPB_EN
    assign epb_hit  = (zero_run == 2'd2) && (cand <= 8'h03);
`else
    assign epb_hit  = 1'b0;
`endif

    assign idle = (state == S_ACC) && (fill == '0) && !byte_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_ACC;
            acc        <= '0;
            fill       <= '0;
            zero_run   <= '0;
            sc_cnt     <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            bit_count  <= '0;
        end else begin
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
            case (state)
                S_ACC: begin
                    if (accept) begin
                        bit_count <= bit_count + CNT_W'(cnt_inc);
                    end
                    if (accept && (wr_mode == M_SC)) begin
                        state  <= S_SC;
                        sc_cnt <= '0;
                    end
                    if (drain && epb_hit) begin
                        // Hold cand in the accumulator; it goes out after the 03.
                        byte_out   <= 8'h03;
                        byte_valid <= 1'b1;
                        zero_run   <= '0;
                        acc        <= acc_app;
                        fill       <= fill_app;
`ifdef BITSTREAM_WRITER_EPB_EN
                        state      <= S_EPB;
`endif
                    end else if (drain) begin
                        byte_out   <= cand;
                        byte_valid <= 1'b1;
                        acc        <= acc_app << 8;
                        fill       <= fill_app - FW'(8);
                        if (cand != 8'h00) begin
                            zero_run <= '0;
                        end else if (zero_run != 2'd2) begin
                            zero_run <= zero_run + 2'd1;
                        end
                    end else begin
                        acc  <= acc_app;
                        fill <= fill_app;
                    end
                end
                S_SC: begin
                    if (out_free) begin
                        byte_out   <= (sc_cnt == 2'd3) ? 8'h01 : 8'h00;
                        byte_valid <= 1'b1;
                        sc_cnt     <= sc_cnt + 2'd1;
                        if (sc_cnt == 2'd3) begin
                            zero_run <= '0;
                            state    <= S_ACC;
                        end
                    end
                end
`ifdef BITSTREAM_WRITER_EPB_EN
                S_EPB: begin
                    if (byte_valid && byte_ready) begin
                        state <= S_ACC;
                    end
                end
`endif
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_writer.sv
// Bench for bitstream_writer: directed cases plus random elements checked against a bit-queue model.
module tb_bitstream_writer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_mode = 3'd0;
    logic [15:0] wr_value = 16'd0;
    logic [4:0]  wr_len = 5'd0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [31:0] bit_count;
    logic        idle;

    always #5 clk = ~clk;

    bitstream_writer #(.ACC_W(48), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode),
        .wr_value(wr_value), .wr_len(wr_len),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .bit_count(bit_count), .idle(idle)
    );

    int          checks = 0;
    int          failures = 0;
    bit          rand_rdy = 1'b0;
    bit          force_rdy = 1'b1;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    bit          bits_q[$];
    int          zr = 0;
    logic [31:0] mcount = 32'd0;

    initial forever begin
        @(negedge clk);
        byte_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (reset_n && byte_valid && byte_ready) got_q.push_back(byte_out);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bail();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "FAIL timeout, stopping");
    endtask

    // Reference model: syntax bits collected in a queue, bytes cut off in eights.
    task automatic emit(input logic [7:0] b);
`ifdef BITSTREAM_WRITER_EPB_EN
        if (zr == 2 && b <= 8'h03) begin
            exp_q.push_back(8'h03);
            zr = 0;
        end
`endif
        exp_q.push_back(b);
        zr = (b == 8'h00) ? ((zr < 2) ? zr + 1 : 2) : 0;
    endtask

    task automatic model_push(input logic [31:0] cw, input int len);
        for (int i = len - 1; i >= 0; i--) bits_q.push_back(cw[i]);
        while (bits_q.size() >= 8) begin
            logic [7:0] b;
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits_q.pop_front()};
            emit(b);
        end
    endtask

    task automatic model_elem(input logic [2:0] m, input logic [15:0] v, input logic [4:0] l);
        int len; int code; int k; int n; int sv;
        case (m)
            3'd0: begin
                len = (l > 16) ? 16 : int'(l);
                mcount += 32'(len);
                model_push(32'(v) & ((32'd1 << len) - 32'd1), len);
            end
            3'd1, 3'd2: begin
                if (m == 3'd1) code = int'(v);
                else begin
                    sv = $signed(v);
                    code = (sv > 0) ? 2 * sv - 1 : -2 * sv;
                end
                k = code + 1;
                n = 0;
                while ((k >> (n + 1)) != 0) n++;
                len = 2 * n + 1;
                mcount += 32'(len);
                model_push(32'(k), len);
            end
            3'd3: begin
                len = 8 - (bits_q.size() % 8);
                mcount += 32'(len);
                model_push(32'd1 << (len - 1), len);
            end
            3'd4: begin
                exp_q.push_back(8'h00); exp_q.push_back(8'h00);
                exp_q.push_back(8'h00); exp_q.push_back(8'h01);
                zr = 0;
                mcount += 32'd32;
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [2:0] m, input logic [15:0] v, input logic [4:0] l);
        int t; bit done;
        t = 0; done = 1'b0;
        wr_valid = 1'b1; wr_mode = m; wr_value = v; wr_len = l;
        while (!done && t < 3000) begin
            #1;
            done = wr_ready;
            @(negedge clk);
            t++;
        end
        wr_valid = 1'b0;
        if (!done) begin
            chk("accept_timeout", done, 1);
            bail();
        end
        model_elem(m, v, l);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!idle && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!idle) begin
            chk("idle_timeout", idle, 1);
            bail();
        end
    endtask

    task automatic expect_lit(input string tag, input logic [63:0] pk, input int n);
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got_q[i], pk[8 * (n - 1 - i) +: 8]);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r;
        logic [15:0] v;
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_bit_count", bit_count, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single fixed byte and its latency.
        send(3'd0, 16'h0067, 5'd8);
        chk("t1_valid_after_N", byte_valid, 0);
        @(negedge clk);
        chk("t1_valid_after_N1", byte_valid, 1);
        chk("t1_byte", byte_out, 8'h67);
        wait_idle();
        chk("t1_count", bit_count, 32'd8);
        chk("t1_idle", idle, 1);
        expect_lit("t1", 64'h67, 1);

        clear_q();
        send(3'd1, 16'd0, 5'd0);
        send(3'd1, 16'd1, 5'd0);
        send(3'd1, 16'd2, 5'd0);
        send(3'd1, 16'd3, 5'd0);
        send(3'd3, 16'd0, 5'd0);
        wait_idle();
        expect_lit("t2", 64'hA648, 2);
        cmp_model("t2_model");
        chk("t2_count", bit_count, 32'd24);

        clear_q();
        send(3'd2, 16'hFFFE, 5'd0);
        send(3'd2, 16'h0001, 5'd0);
        send(3'd2, 16'h0000, 5'd0);
        send(3'd0, 16'h0000, 5'd7);
        wait_idle();
        expect_lit("t3", 64'h2A80, 2);
        chk("t3_count", bit_count, 32'd40);

        clear_q();
        send(3'd0, 16'h0000, 5'd16);
        send(3'd0, 16'h0001, 5'd8);
        wait_idle();
`ifdef BITSTREAM_WRITER_EPB_EN
        expect_lit("t4", 64'h00000301, 4);
`else
        expect_lit("t4", 64'h000001, 3);
`endif
        cmp_model("t4_model");
        chk("t4_count", bit_count, 32'd64);

        // Start code blocked until byte-aligned, then passes zeros untouched.
        clear_q();
        send(3'd0, 16'h0000, 5'd3);
        wr_valid = 1'b1; wr_mode = 3'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_sc_blocked", wr_ready, 0);
            @(negedge clk);
        end
        wr_valid = 1'b0; wr_mode = 3'd3;
        #1;
        chk("t5_rbsp_ready", wr_ready, 1);
        @(negedge clk);
        send(3'd3, 16'd0, 5'd0);
        send(3'd0, 16'h0000, 5'd8);
        send(3'd0, 16'h0000, 5'd8);
        send(3'd4, 16'd0, 5'd0);
        send(3'd0, 16'h0000, 5'd8);
        wait_idle();
        expect_lit("t5", 64'h1000000000000100, 8);
        chk("t5_count", bit_count, 32'd128);

        // Output stall with a long ue codeword pending.
        clear_q();
        force_rdy = 1'b0;
        @(negedge clk);
        send(3'd0, 16'h0007, 5'd3);
        send(3'd1, 16'd32766, 5'd0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t6_hold_valid", byte_valid, 1);
            chk("t6_hold_byte", byte_out, 8'hE0);
            chk("t6_hold_ready", wr_ready, 0);
            @(negedge clk);
        end
        force_rdy = 1'b1;
        wait_idle();
        expect_lit("t6", 64'hE0007FFF, 4);
        chk("t6_count", bit_count, 32'd160);

        // Random elements with random output backpressure.
        clear_q();
        rand_rdy = 1'b1;
        for (int e = 0; e < 250; e++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                send(3'd0, 16'($urandom), 5'($urandom_range(0, 20)));
            end else if (r < 60) begin
                send(3'd1, 16'($urandom_range(0, 32766)), 5'd0);
            end else if (r < 85) begin
                v = 16'(int'($urandom_range(0, 32766)) - 16383);
                send(3'd2, v, 5'd0);
            end else if (r < 92) begin
                send(3'd3, 16'd0, 5'd0);
            end else if (r < 97) begin
                if (bits_q.size() != 0) send(3'd3, 16'd0, 5'd0);
                send(3'd4, 16'd0, 5'd0);
            end else begin
                send(3'($urandom_range(5, 7)), 16'($urandom), 5'($urandom_range(0, 31)));
            end
        end
        if (bits_q.size() != 0) send(3'd3, 16'd0, 5'd0);
        wait_idle();
        cmp_model("rand");
        chk("rand_count", bit_count, mcount);

        // Reset in the middle of a stalled stream.
        rand_rdy = 1'b0;
        force_rdy = 1'b0;
        @(negedge clk);
        send(3'd0, 16'hABCD, 5'd16);
        repeat (2) @(negedge clk);
        chk("t8_pending_valid", byte_valid, 1);
        chk("t8_pending_byte", byte_out, 8'hAB);
        reset_n = 1'b0;
        #1;
        chk("t8_rst_valid", byte_valid, 0);
        chk("t8_rst_byte", byte_out, 8'h00);
        chk("t8_rst_count", bit_count, 32'd0);
        chk("t8_rst_ready", wr_ready, 1);
        chk("t8_rst_idle", idle, 1);
        @(negedge clk);
        reset_n = 1'b1;
        clear_q();
        bits_q.delete();
        zr = 0;
        mcount = 32'd0;
        force_rdy = 1'b1;
        repeat (2) @(negedge clk);
        send(3'd0, 16'h005A, 5'd8);
        wait_idle();
        expect_lit("t8_after", 64'h5A, 1);
        chk("t8_after_count", bit_count, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
